denoise_window_sequencer: RTL and testbench

//  Sequences one raster-order frame of color-mask pixels into NxN neighbourhood windows for the denoise stage.

---
 rtl/denoise_window_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_denoise_window_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/denoise_window_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : denoise_window_sequencer
// Brief    : Turns a raster frame of color-mask pixels into border-masked NxN
//            windows and self-flushes the trailing rows/columns.
// Revision : 1.0  initial release
// =============================================================================
module denoise_window_sequencer #(
   parameter int N_SIZE = 5,
   parameter int COLORS = 2,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [COLORS:0]          in_pix,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [COLORS:0]          win [0:N_SIZE-1][0:N_SIZE-1],
   output logic                     win_valid,
   output logic [$clog2(IMG_W)-1:0] win_x,
   output logic [$clog2(IMG_H)-1:0] win_y,
   output logic                     busy,
   output logic                     frame_done
);
   localparam int H  = N_SIZE / 2;
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int FW = $clog2(H * IMG_W + H + 1);
   localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_PRIME   = XW'(H);
   localparam logic [YW-1:0] Y_PRIME   = YW'(H);
   localparam logic [FW-1:0] FLUSH_LEN = FW'(H * IMG_W + H);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DONE} state_t;
   typedef logic [COLORS:0] pix_t;

   state_t        state_q, state_d;
   logic [XW-1:0] in_col_q, in_col_d, cen_x_q, cen_x_d, win_x_q, win_x_d;
   logic [YW-1:0] in_row_q, in_row_d, cen_y_q, cen_y_d, win_y_q, win_y_d;
   logic [FW-1:0] flush_cnt_q, flush_cnt_d;
   logic          in_ready_q, in_ready_d, busy_q, busy_d;
   logic          win_valid_q, win_valid_d, frame_done_q, frame_done_d;
   pix_t          win_q [0:N_SIZE-1][0:N_SIZE-1];
   pix_t          win_d [0:N_SIZE-1][0:N_SIZE-1];

   // Line buffers and shift window hold no reset: stale content is masked by position.
   pix_t line_q  [0:N_SIZE-2][0:IMG_W-1];
   pix_t shift_q [0:N_SIZE-1][0:N_SIZE-1];
   pix_t new_col [0:N_SIZE-1];
   logic row_ok  [0:N_SIZE-1];
   logic col_ok  [0:N_SIZE-1];
   logic advance, emit;

   always_comb begin
      advance = (in_ready_q && in_valid) ||
                (state_q == S_FLUSH && flush_cnt_q != FLUSH_LEN);
      emit    = advance && (state_q != S_FILL ||
                            (in_row_q == Y_PRIME && in_col_q == X_PRIME));
      for (int r = 0; r < N_SIZE - 1; r++) new_col[r] = line_q[r][in_col_q];
      new_col[N_SIZE-1] = (state_q == S_FLUSH) ? '0 : in_pix;
      for (int i = 0; i < N_SIZE; i++) begin
         row_ok[i] = ((int'(cen_y_q) + i - H) >= 0) && ((int'(cen_y_q) + i - H) < IMG_H);
         col_ok[i] = ((int'(cen_x_q) + i - H) >= 0) && ((int'(cen_x_q) + i - H) < IMG_W);
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         for (int r = 0; r < N_SIZE - 1; r++) line_q[r][in_col_q] <= new_col[r+1];
         for (int r = 0; r < N_SIZE; r++) begin
            for (int c = 0; c < N_SIZE - 1; c++) shift_q[r][c] <= shift_q[r][c+1];
            shift_q[r][N_SIZE-1] <= new_col[r];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      in_col_d     = in_col_q;
      in_row_d     = in_row_q;
      cen_x_d      = cen_x_q;
      cen_y_d      = cen_y_q;
      flush_cnt_d  = flush_cnt_q;
      win_x_d      = win_x_q;
      win_y_d      = win_y_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      win_d        = win_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_FILL;
               in_col_d    = '0;
               in_row_d    = '0;
               cen_x_d     = '0;
               cen_y_d     = '0;
               flush_cnt_d = '0;
            end
         end
         S_FILL:   if (advance && in_row_q == Y_PRIME && in_col_q == X_PRIME) state_d = S_STREAM;
         S_STREAM: if (advance && in_row_q == Y_LAST && in_col_q == X_LAST) state_d = S_FLUSH;
         S_FLUSH: begin
            // One idle cycle after the last virtual pixel lets the final window drain first.
            if (flush_cnt_q == FLUSH_LEN) begin
               state_d      = S_DONE;
               frame_done_d = 1'b1;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         if (in_col_q == X_LAST) begin
            in_col_d = '0;
            if (state_q != S_FLUSH && in_row_q != Y_LAST) in_row_d = in_row_q + 1'b1;
         end else begin
            in_col_d = in_col_q + 1'b1;
         end
      end

      if (emit) begin
         win_valid_d = 1'b1;
         win_x_d     = cen_x_q;
         win_y_d     = cen_y_q;
         for (int r = 0; r < N_SIZE; r++) begin
            for (int c = 0; c < N_SIZE; c++) begin
               win_d[r][c] = (row_ok[r] && col_ok[c]) ?
                             ((c == N_SIZE - 1) ? new_col[r] : shift_q[r][c+1]) : '0;
            end
         end
         if (cen_x_q == X_LAST) begin
            cen_x_d = '0;
            cen_y_d = (cen_y_q == Y_LAST) ? '0 : cen_y_q + 1'b1;
         end else begin
            cen_x_d = cen_x_q + 1'b1;
         end
      end

      in_ready_d = (state_d == S_FILL) || (state_d == S_STREAM);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         in_col_q     <= '0;
         in_row_q     <= '0;
         cen_x_q      <= '0;
         cen_y_q      <= '0;
         flush_cnt_q  <= '0;
         win_x_q      <= '0;
         win_y_q      <= '0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < N_SIZE; r++)
            for (int c = 0; c < N_SIZE; c++) win_q[r][c] <= '0;
      end else begin
         state_q      <= state_d;
         in_col_q     <= in_col_d;
         in_row_q     <= in_row_d;
         cen_x_q      <= cen_x_d;
         cen_y_q      <= cen_y_d;
         flush_cnt_q  <= flush_cnt_d;
         win_x_q      <= win_x_d;
         win_y_q      <= win_y_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         win_q        <= win_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign win        = win_q;
   assign win_valid  = win_valid_q;
   assign win_x      = win_x_q;
   assign win_y      = win_y_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_denoise_window_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_denoise_window_sequencer
// Brief    : Scoreboard bench: expected windows queued at issue, popped on win_valid.
// Revision : 1.0  initial release
// =============================================================================
module tb_denoise_window_sequencer;
   localparam int N  = 5;
   localparam int C  = 2;
   localparam int W  = 8;
   localparam int HT = 6;
   localparam int WB = N * N * (C + 1);

   logic         clk      = 1'b0;
   logic         reset_n  = 1'b0;
   logic         start    = 1'b0;
   logic         in_valid = 1'b0;
   logic [C:0]   in_pix   = '0;
   logic         in_ready, win_valid, busy, frame_done;
   logic [C:0]   win [0:N-1][0:N-1];
   logic [2:0]   win_x, win_y;

   typedef struct {
      int            x;
      int            y;
      logic [WB-1:0] w;
   } exp_t;

   exp_t          sb[$];
   exp_t          m_exp;
   logic [WB-1:0] m_act;
   logic [WB-1:0] first_win;
   int n_vec = 0, n_err = 0, cyc = 0, n_win = 0, n_done = 0;
   int first_cyc = -1, acc18_cyc = -1, last_cyc = -1;

   denoise_window_sequencer #(.N_SIZE(N), .COLORS(C), .IMG_W(W), .IMG_H(HT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .in_pix     (in_pix),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .win        (win),
      .win_valid  (win_valid),
      .win_x      (win_x),
      .win_y      (win_y),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [C:0] pix(input int pat, input int x, input int y);
      case (pat)
         0:       return 3'b101;
         1:       return {1'b1, 1'b0, (((x + y) % 2) != 0)};
         default: return 3'b110;
      endcase
   endfunction

   function automatic logic [WB-1:0] model(input int pat, input int cx, input int cy);
      logic [WB-1:0] v = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            int yy = cy - 2 + r;
            int xx = cx - 2 + c;
            if (yy >= 0 && yy < HT && xx >= 0 && xx < W) v[(r*N+c)*(C+1) +: (C+1)] = pix(pat, xx, yy);
         end
      return v;
   endfunction

   function automatic logic [WB-1:0] pack_win();
      logic [WB-1:0] v = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) v[(r*N+c)*(C+1) +: (C+1)] = win[r][c];
      return v;
   endfunction

   // Monitor: every presented window is popped and compared against the queue head.
   always @(negedge clk) begin
      if (win_valid) begin
         m_act = pack_win();
         if (n_win == 0) begin
            first_cyc = cyc;
            first_win = m_act;
         end
         n_win++;
         last_cyc = cyc;
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL window_unexpected: got (%0d,%0d) expected none", win_x, win_y);
         end else begin
            m_exp = sb.pop_front();
            if (win_x !== 3'(m_exp.x) || win_y !== 3'(m_exp.y) || m_act !== m_exp.w) begin
               n_err++;
               $display("FAIL window: got (%0d,%0d) %h expected (%0d,%0d) %h",
                        win_x, win_y, m_act, m_exp.x, m_exp.y, m_exp.w);
            end
         end
      end
      if (frame_done) begin
         n_done++;
         chk("done_after_last_window", 64'(cyc - last_cyc), 64'd1);
         chk("done_scoreboard_empty", 64'(sb.size()), 64'd0);
      end
   end

   task automatic push_frame(input int pat, input int n);
      for (int i = 0; i < n; i++) sb.push_back('{i % W, i / W, model(pat, i % W, i / W)});
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int pat, input int npix, input bit gaps, input int start_at);
      for (int i = 0; i < npix; i++) begin
         int  g  = 0;
         bit  ok = 1'b0;
         in_pix   = pix(pat, i % W, i / W);
         in_valid = 1'b1;
         start    = (i == start_at);
         while (!ok && g < 100) begin
            ok = in_ready;
            @(posedge clk); #1;
            g++;
         end
         if (!ok) chk("accept_timeout", 64'd0, 64'd1);
         start = 1'b0;
         if (i == 18) acc18_cyc = cyc;
         if (gaps) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input int pat, input bit gaps, input int start_at);
      int d0 = n_done;
      int g  = 0;
      n_win = 0;
      push_frame(pat, W * HT);
      do_start();
      feed(pat, W * HT, gaps, start_at);
      while (n_done == d0 && g < 400) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("frame_done_once", 64'(n_done), 64'(d0 + 1));
      chk("window_count", 64'(n_win), 64'd48);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, {59'd0, in_ready, win_valid, busy, frame_done, 1'b0}, 64'd0);
      chk({tag, "_xy"}, {58'd0, win_x, win_y}, 64'd0);
      chk({tag, "_win"}, 64'(pack_win() != '0), 64'd0);
   endtask

   initial begin
      int nv;
      // Reset state and no ready until start
      #12;
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("ready_before_start", {62'd0, in_ready, busy}, 64'd0);

      // Full frame of 3'b101, continuous input
      run_frame(0, 1'b0, -1);
      chk("first_window_latency", 64'(first_cyc), 64'(acc18_cyc));
      nv = 0;
      for (int k = 0; k < N * N; k++) nv += int'(first_win[k*(C+1) + C]);
      chk("first_window_valid_entries", 64'(nv), 64'd9);
      chk("first_window_centre", 64'(first_win[36 +: 3]), 64'h5);
      chk("first_window_corner_br", 64'(first_win[72 +: 3]), 64'h5);
      chk("first_window_corner_tl", 64'(first_win[0 +: 3]), 64'h0);

      // Same frame with in_valid gaps
      run_frame(0, 1'b1, -1);
      // Checkerboard payload
      run_frame(1, 1'b0, -1);
      // start pulsed mid-stream
      run_frame(0, 1'b0, 25);

      // Aborted frame: 30 pixels give 12 windows, then asynchronous reset mid-cycle
      n_win = 0;
      push_frame(0, 12);
      do_start();
      feed(0, 30, 1'b0, -1);
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      chk_all_zero("midframe_reset");
      chk("aborted_windows", 64'(n_win), 64'd12);
      chk("aborted_scoreboard", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_frame(2, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
